// File: rtl/cordic_vectoring_if.sv
// Streaming handshake bundle for the vectoring CORDIC: (x, y) in, (angle, magnitude) out.
interface cordic_vectoring_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x_in;
  logic [15:0] y_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] angle;
  logic [15:0] magnitude;

  // Core side
  modport slave (
    input  in_valid, x_in, y_in, out_ready,
    output in_ready, out_valid, angle, magnitude
  );

  // Producer/consumer side
  modport master (
    output in_valid, x_in, y_in, out_ready,
    input  in_ready, out_valid, angle, magnitude
  );
endinterface

// File: rtl/cordic_vectoring.sv
// Iterative vectoring-mode CORDIC: Cartesian (x, y) to phase (2^32 = full turn)
// and gain-compensated magnitude, one micro-rotation per clock.
module cordic_vectoring (
  input  logic              clk,
  input  logic              rst,
  cordic_vectoring_if.slave io_bus
);

  localparam int unsigned ITER  = 13;
  localparam int unsigned K_INV = 19898;
  localparam int unsigned IN_W  = 16;
  localparam int unsigned DW    = 20;
  localparam int unsigned ZW    = 32;
  localparam int unsigned PW    = 40;
  localparam int unsigned IW    = 4;
  localparam int unsigned MW    = 16;
  localparam int unsigned FRAC  = 15;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ITER  = 2'd1,
    S_SCALE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic                 w_in_ready;
  logic                 w_capture;

  logic signed [DW-1:0] r_x;
  logic signed [DW-1:0] r_y;
  logic        [ZW-1:0] r_z;
  logic        [IW-1:0] r_iter;
  logic                 r_zero;
  logic                 r_out_valid;
  logic        [ZW-1:0] r_angle;
  logic        [MW-1:0] r_mag;

  logic signed [DW-1:0] w_xin_ext;
  logic signed [DW-1:0] w_yin_ext;
  logic signed [DW-1:0] w_x0;
  logic signed [DW-1:0] w_y0;
  logic        [ZW-1:0] w_z0;
  logic signed [DW-1:0] w_xs;
  logic signed [DW-1:0] w_ys;
  logic signed [PW-1:0] w_prod;
  logic signed [PW-1:0] w_scaled;
  logic        [MW-1:0] w_mag;

  // arctan(2^-i) in turn units scaled by 2^32
  function automatic logic [ZW-1:0] theta(input logic [IW-1:0] idx);
    logic [ZW-1:0] t;
    case (idx)
      4'd0:    t = 32'h2000_0000;
      4'd1:    t = 32'h12E4_051E;
      4'd2:    t = 32'h09FB_385B;
      4'd3:    t = 32'h0511_11D4;
      4'd4:    t = 32'h028B_0D43;
      4'd5:    t = 32'h0145_D7E1;
      4'd6:    t = 32'h00A2_F61E;
      4'd7:    t = 32'h0051_7C55;
      4'd8:    t = 32'h0028_BE53;
      4'd9:    t = 32'h0014_5F2F;
      4'd10:   t = 32'h000A_2F98;
      4'd11:   t = 32'h0005_17CC;
      4'd12:   t = 32'h0002_8BE6;
      default: t = '0;
    endcase
    return t;
  endfunction

  // Widen inputs so that negating -32768 cannot overflow
  assign w_xin_ext = {{(DW-IN_W){io_bus.x_in[IN_W-1]}}, io_bus.x_in};
  assign w_yin_ext = {{(DW-IN_W){io_bus.y_in[IN_W-1]}}, io_bus.y_in};

  // Pre-rotate left half-plane vectors by +/-90 degrees into the right half-plane
  always_comb begin
    w_x0 = w_xin_ext;
    w_y0 = w_yin_ext;
    w_z0 = '0;
    if (w_xin_ext[DW-1]) begin
      if (!w_yin_ext[DW-1]) begin
        w_x0 = w_yin_ext;
        w_y0 = -w_xin_ext;
        w_z0 = 32'h4000_0000;
      end else begin
        w_x0 = -w_yin_ext;
        w_y0 = w_xin_ext;
        w_z0 = 32'hC000_0000;
      end
    end
  end

  assign w_xs = r_x >>> r_iter;
  assign w_ys = r_y >>> r_iter;

  // Gain compensation with round-half-up, clamped into the unsigned 16-bit range
  assign w_prod   = {{(PW-DW){r_x[DW-1]}}, r_x} * $signed(PW'(K_INV))
                  + $signed(PW'(1 << (FRAC - 1)));
  assign w_scaled = w_prod >>> FRAC;

  always_comb begin
    w_mag = w_scaled[MW-1:0];
    if (w_scaled[PW-1]) begin
      w_mag = '0;
    end else if (|w_scaled[PW-2:MW]) begin
      w_mag = '1;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and handshake decode; in_ready depends on state (and reset) only
  always_comb begin
    w_next     = r_state;
    w_in_ready = 1'b0;
    w_capture  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = !rst;
        if (io_bus.in_valid) begin
          w_capture = 1'b1;
          w_next    = S_ITER;
        end
      end
      S_ITER: begin
        if (r_iter == IW'(ITER - 1)) begin
          w_next = S_SCALE;
        end
      end
      S_SCALE: begin
        w_next = S_DONE;
      end
      S_DONE: begin
        if (r_out_valid && io_bus.out_ready) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Datapath: capture, micro-rotations, scaling and result hold
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x         <= '0;
      r_y         <= '0;
      r_z         <= '0;
      r_iter      <= '0;
      r_zero      <= 1'b0;
      r_out_valid <= 1'b0;
      r_angle     <= '0;
      r_mag       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_capture) begin
            r_x    <= w_x0;
            r_y    <= w_y0;
            r_z    <= w_z0;
            r_iter <= '0;
            r_zero <= (io_bus.x_in == '0) && (io_bus.y_in == '0);
          end
        end
        S_ITER: begin
          if (!r_y[DW-1]) begin
            r_x <= r_x + w_ys;
            r_y <= r_y - w_xs;
            r_z <= r_z + theta(r_iter);
          end else begin
            r_x <= r_x - w_ys;
            r_y <= r_y + w_xs;
            r_z <= r_z - theta(r_iter);
          end
          r_iter <= r_iter + IW'(1);
        end
        S_SCALE: begin
          r_angle     <= r_zero ? '0 : r_z;
          r_mag       <= r_zero ? '0 : w_mag;
          r_out_valid <= 1'b1;
        end
        S_DONE: begin
          if (r_out_valid && io_bus.out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign io_bus.in_ready  = w_in_ready;
  assign io_bus.out_valid = r_out_valid;
  assign io_bus.angle     = r_angle;
  assign io_bus.magnitude = r_mag;

endmodule

// File: tb/tb_cordic_vectoring.sv
// Directed bench for cordic_vectoring with a floating-point reference and result scoreboard.
module tb_cordic_vectoring;

  localparam real PI   = 3.14159265358979323846;
  localparam real TURN = 4294967296.0;
  localparam int  ATOL = 32'h0008_0000;
  localparam int  MTOL = 4;

  typedef struct {
    logic [31:0] ang;
    logic [15:0] mag;
    int          atol;
    int          mtol;
    string       tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  cordic_vectoring_if u_if ();

  cordic_vectoring dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (u_if.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $error("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_tol(input string tag, input logic [63:0] obs, input logic [63:0] exp,
                           input int err, input int tol);
    total++;
    assert (((err <= tol) && (err >= -tol)) === 1'b1) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h err=%0d tol=%0d", tag, obs, exp, err, tol);
    end
  endtask

  function automatic exp_t model(input int x, input int y, input int atol, input int mtol,
                                 input string tag);
    exp_t e;
    real  a;
    real  m;
    e.atol = atol;
    e.mtol = mtol;
    e.tag  = tag;
    if (x == 0 && y == 0) begin
      e.ang = '0;
      e.mag = '0;
    end else begin
      a = $atan2(real'(y), real'(x)) / (2.0 * PI) * TURN;
      if (a < 0.0) a = a + TURN;
      e.ang = 32'(longint'(a));
      m = $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
      e.mag = 16'(longint'(m));
    end
    return e;
  endfunction

  // Drive one pair; returns at the falling edge after the accepting edge
  task automatic send(input int x, input int y, input bit push, input int atol,
                      input int mtol, input string tag);
    int n = 0;
    while (u_if.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_rdy"}, 64'(u_if.in_ready), 64'(1));
    if (push) sb.push_back(model(x, y, atol, mtol, tag));
    u_if.x_in     = 16'(x);
    u_if.y_in     = 16'(y);
    u_if.in_valid = 1'b1;
    @(negedge clk);
    u_if.in_valid = 1'b0;
  endtask

  // Wait (bounded) for a result and compare it with the oldest expectation
  task automatic collect();
    int               n = 0;
    bit               busy = 1'b0;
    exp_t             e;
    logic signed [31:0] d;
    while (u_if.out_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
      if (u_if.in_ready !== 1'b0) busy = 1'b1;
    end
    check_eq("sb_nonempty", 64'(sb.size() != 0), 64'(1));
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check_eq({e.tag, "_lat"}, 64'(n), 64'(14));
      check_eq({e.tag, "_busy"}, 64'(busy), 64'(0));
      d = u_if.angle - e.ang;
      check_tol({e.tag, "_ang"}, 64'(u_if.angle), 64'(e.ang), int'(d), e.atol);
      check_tol({e.tag, "_mag"}, 64'(u_if.magnitude), 64'(e.mag),
                int'(u_if.magnitude) - int'(e.mag), e.mtol);
    end
  endtask

  task automatic accept(input string tag);
    u_if.out_ready = 1'b1;
    @(negedge clk);
    u_if.out_ready = 1'b0;
    check_eq({tag, "_ov_drop"}, 64'(u_if.out_valid), 64'(0));
    check_eq({tag, "_rdy_back"}, 64'(u_if.in_ready), 64'(1));
  endtask

  task automatic run(input int x, input int y, input int atol, input int mtol, input string tag);
    send(x, y, 1'b1, atol, mtol, tag);
    collect();
    accept(tag);
  endtask

  initial begin
    int          rx;
    int          ry;
    bit          seen;
    logic [31:0] hold_ang;
    logic [15:0] hold_mag;

    u_if.in_valid  = 1'b0;
    u_if.x_in      = '0;
    u_if.y_in      = '0;
    u_if.out_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_rdy", 64'(u_if.in_ready), 64'(0));
    check_eq("rst_ov", 64'(u_if.out_valid), 64'(0));
    check_eq("rst_ang", 64'(u_if.angle), 64'(0));
    check_eq("rst_mag", 64'(u_if.magnitude), 64'(0));
    rst = 1'b0;
    #1;
    check_eq("rst_rel_rdy", 64'(u_if.in_ready), 64'(1));
    @(negedge clk);

    // Cardinal axes, diagonals, extremes, zero
    run(16384, 0, ATOL, MTOL, "px");
    run(0, 16384, ATOL, MTOL, "py");
    run(-16384, 0, ATOL, MTOL, "nx");
    run(0, -16384, ATOL, MTOL, "ny");
    run(-16384, -16384, ATOL, MTOL, "diag3");
    run(16384, -16384, ATOL, MTOL, "diag4");
    run(-32768, -32768, ATOL, MTOL, "ext_nn");
    run(32767, -32768, ATOL, MTOL, "ext_pn");
    run(-32768, 32767, ATOL, MTOL, "ext_np");
    run(0, 0, 0, 0, "zero");

    // A few random vectors of usable amplitude
    for (int i = 0; i < 4; i++) begin
      rx = int'($urandom_range(65535)) - 32768;
      ry = int'($urandom_range(65535)) - 32768;
      if (rx > -1024 && rx < 1024 && ry > -1024 && ry < 1024) rx = 2000;
      run(rx, ry, ATOL, MTOL, "rand");
    end

    // Backpressure with in_valid toggling while the result is held
    send(5000, 7000, 1'b1, ATOL, MTOL, "bp");
    collect();
    hold_ang = u_if.angle;
    hold_mag = u_if.magnitude;
    for (int i = 0; i < 5; i++) begin
      u_if.in_valid = ~u_if.in_valid;
      u_if.x_in     = 16'($urandom);
      u_if.y_in     = 16'($urandom);
      @(negedge clk);
      check_eq("bp_ang_hold", 64'(u_if.angle), 64'(hold_ang));
      check_eq("bp_mag_hold", 64'(u_if.magnitude), 64'(hold_mag));
      check_eq("bp_rdy_low", 64'(u_if.in_ready), 64'(0));
      check_eq("bp_ov_high", 64'(u_if.out_valid), 64'(1));
    end
    u_if.in_valid = 1'b0;
    accept("bp");
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (u_if.out_valid !== 1'b0 || u_if.in_ready !== 1'b1) seen = 1'b1;
    end
    check_eq("bp_no_phantom", 64'(seen), 64'(0));

    // Reset during iteration 6 discards the in-flight result
    send(12000, -5000, 1'b0, ATOL, MTOL, "rm");
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rm_ov", 64'(u_if.out_valid), 64'(0));
    check_eq("rm_ang", 64'(u_if.angle), 64'(0));
    check_eq("rm_mag", 64'(u_if.magnitude), 64'(0));
    check_eq("rm_rdy", 64'(u_if.in_ready), 64'(1));
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (u_if.out_valid !== 1'b0) seen = 1'b1;
    end
    check_eq("rm_no_pulse", 64'(seen), 64'(0));
    run(1000, 1000, 32'h0010_0000, 6, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
